// File: rtl/vram_arbiter_if.sv
// Bundles the video requester, CPU requester and RAM-side signals of the VRAM arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface vram_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 16
);
    logic          vid_active;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ready;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  vid_active, vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output vid_ready, vid_rvalid, vid_rdata,
        output cpu_ready, cpu_rvalid, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output vid_active, vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  vid_ready, vid_rvalid, vid_rdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous VRAM between the video fetcher and the CPU:
// video wins during active display (with a CPU starvation guard), the CPU wins in blanking.
module vram_arbiter #(
    parameter int AW         = 11,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic           clock,
    input  logic           nreset,
    vram_arbiter_if.slave  bus
);
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_e;

    logic          cpu_grant;
    logic          vid_grant;
    logic          starved;

    logic [SW-1:0] starve_q,     starve_d;
    logic          mem_en_q,     mem_en_d;
    logic          mem_we_q,     mem_we_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [DW-1:0] mem_wdata_q,  mem_wdata_d;
    owner_e        tag1_q,       tag1_d;
    owner_e        tag2_q;
    logic          vid_rvalid_q, vid_rvalid_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic [DW-1:0] vid_rdata_q,  vid_rdata_d;
    logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;

    // Grants are gated by reset so nothing is accepted while the pipeline is held clear.
    always_comb begin
        starved   = (STARVE_MAX != 0) && (starve_q == STARVE_LIM);
        cpu_grant = nreset && bus.cpu_req &&
                    (!bus.vid_req || !bus.vid_active || starved);
        vid_grant = nreset && bus.vid_req && !cpu_grant;
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.cpu_req || cpu_grant) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end

        mem_en_d    = cpu_grant || vid_grant;
        mem_we_d    = cpu_grant && bus.cpu_we;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag1_d      = OWN_NONE;
        if (cpu_grant) begin
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
            tag1_d      = bus.cpu_we ? OWN_NONE : OWN_CPU;
        end else if (vid_grant) begin
            mem_addr_d  = bus.vid_addr;
            tag1_d      = OWN_VID;
        end

        // RAM data is valid while the op's tag sits in stage 2; steer it to its owner.
        vid_rvalid_d = (tag2_q == OWN_VID);
        cpu_rvalid_d = (tag2_q == OWN_CPU);
        vid_rdata_d  = vid_rvalid_d ? bus.mem_rdata : vid_rdata_q;
        cpu_rdata_d  = cpu_rvalid_d ? bus.mem_rdata : cpu_rdata_q;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            starve_q     <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tag1_q       <= OWN_NONE;
            tag2_q       <= OWN_NONE;
            vid_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            vid_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            starve_q     <= starve_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag1_q;
            vid_rvalid_q <= vid_rvalid_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vid_rdata_q  <= vid_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    assign bus.vid_ready  = vid_grant;
    assign bus.cpu_ready  = cpu_grant;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.vid_rvalid = vid_rvalid_q;
    assign bus.vid_rdata  = vid_rdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, hand sequences for reset and strict priority,
// and randomized traffic scored against a transaction-level model of the arbiter and RAM.
module tb_vram_arbiter;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int SM = 8;

    logic clock = 1'b0;
    logic nreset;
    logic preload;

    always #5 clock = ~clock;

    vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    vram_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();

    vram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clock (clock),
        .nreset(nreset),
        .bus   (bus)
    );

    vram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(0)) dut0 (
        .clock (clock),
        .nreset(nreset),
        .bus   (bus0)
    );

    // Synchronous single-port RAM; preload fills each word with its own address.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= DW'(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end
    assign bus0.mem_rdata = '0;

    typedef struct {
        int            due;
        bit            cpu;
        logic [DW-1:0] data;
    } ret_t;

    typedef struct {
        logic          va, vr;
        logic [AW-1:0] vaddr;
        logic          cr, cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          evr, ecr;
    } vec_t;

    ret_t          rq[$];
    vec_t          vt[$];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    int            cyc, checks, errors, m_starve;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_vdata, e_cdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        m_starve = 0;
        e_addr   = '0;
        e_wdata  = '0;
        e_vdata  = '0;
        e_cdata  = '0;
    endtask

    task automatic check_returns();
        bit ev, ec;
        ev = 1'b0;
        ec = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].cpu) begin ec = 1'b1; e_cdata = rq[0].data; end
            else           begin ev = 1'b1; e_vdata = rq[0].data; end
            void'(rq.pop_front());
        end
        chk("vid_rvalid", bus.vid_rvalid, ev);
        chk("cpu_rvalid", bus.cpu_rvalid, ec);
        chk("vid_rdata",  bus.vid_rdata,  e_vdata);
        chk("cpu_rdata",  bus.cpu_rdata,  e_cdata);
    endtask

    // Called at a falling edge: drives one cycle of requests, scores it, returns at the next falling edge.
    task automatic run_cycle(input logic va, input logic vr, input logic [AW-1:0] vaddr,
                             input logic cr, input logic cwe, input logic [AW-1:0] caddr,
                             input logic [DW-1:0] cwd, output logic got_vr, output logic got_cr);
        bit exp_cr, exp_vr;
        bus.vid_active = va;
        bus.vid_req    = vr;
        bus.vid_addr   = vaddr;
        bus.cpu_req    = cr;
        bus.cpu_we     = cwe;
        bus.cpu_addr   = caddr;
        bus.cpu_wdata  = cwd;
        #1;
        got_vr = bus.vid_ready;
        got_cr = bus.cpu_ready;
        exp_cr = cr && (!vr || !va || m_starve == SM);
        exp_vr = vr && !exp_cr;
        chk("vid_ready", got_vr, exp_vr);
        chk("cpu_ready", got_cr, exp_cr);
        if (exp_cr) begin
            e_addr  = caddr;
            e_wdata = cwd;
            if (cwe) model_mem[caddr] = cwd;
            else     rq.push_back('{cyc + 3, 1'b1, model_mem[caddr]});
        end else if (exp_vr) begin
            e_addr = vaddr;
            rq.push_back('{cyc + 3, 1'b0, model_mem[vaddr]});
        end
        if (!cr || exp_cr)  m_starve = 0;
        else if (m_starve < SM) m_starve++;
        @(negedge clock);
        cyc++;
        chk("mem_en",    bus.mem_en,    exp_cr || exp_vr);
        chk("mem_we",    bus.mem_we,    exp_cr && cwe);
        chk("mem_addr",  bus.mem_addr,  e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wdata);
        check_returns();
    endtask

    task automatic add(input logic va, input logic vr, input logic [AW-1:0] vaddr,
                       input logic cr, input logic cwe, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwd, input logic evr, input logic ecr);
        vt.push_back('{va, vr, vaddr, cr, cwe, caddr, cwd, evr, ecr});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) add(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vid_ready"},  bus.vid_ready,  1'b0);
        chk({tag, "_cpu_ready"},  bus.cpu_ready,  1'b0);
        chk({tag, "_mem_en"},     bus.mem_en,     1'b0);
        chk({tag, "_mem_we"},     bus.mem_we,     1'b0);
        chk({tag, "_mem_addr"},   bus.mem_addr,   '0);
        chk({tag, "_mem_wdata"},  bus.mem_wdata,  '0);
        chk({tag, "_vid_rvalid"}, bus.vid_rvalid, 1'b0);
        chk({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 1'b0);
        chk({tag, "_vid_rdata"},  bus.vid_rdata,  '0);
        chk({tag, "_cpu_rdata"},  bus.cpu_rdata,  '0);
    endtask

    initial begin
        logic gvr, gcr;
        logic va, vr, cr, cwe, vpend, cpend;
        logic [AW-1:0] vaddr, caddr;
        logic [DW-1:0] cwd;

        checks  = 0;
        errors  = 0;
        cyc     = 0;
        nreset  = 1'b0;
        preload = 1'b1;
        {bus.vid_active, bus.vid_req, bus.cpu_req, bus.cpu_we} = '0;
        bus.vid_addr = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        {bus0.vid_active, bus0.vid_req, bus0.cpu_req, bus0.cpu_we} = '0;
        bus0.vid_addr = '0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) model_mem[i] = DW'(i);
        model_reset();

        // Reset state with requests pending
        @(negedge clock);
        bus.vid_req = 1'b1;
        bus.cpu_req = 1'b1;
        @(negedge clock);
        check_all_zero("reset");
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
        nreset  = 1'b1;
        preload = 1'b0;

        // Directed vector table
        for (int i = 0; i < 4; i++) add(1'b1, 1'b1, AW'(16 + i), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(4);
        add(1'b0, 1'b0, '0, 1'b1, 1'b1, 11'h7FF, 16'h0123, 1'b0, 1'b1);
        add(1'b0, 1'b0, '0, 1'b1, 1'b0, 11'h7FF, 16'h0000, 1'b0, 1'b1);
        idle(4);
        for (int i = 1; i <= 18; i++)
            add(1'b1, 1'b1, AW'(i), 1'b1, 1'b0, 11'h020, '0, !(i == 9 || i == 18), (i == 9 || i == 18));
        idle(1);
        add(1'b0, 1'b1, 11'h040, 1'b1, 1'b0, 11'h041, '0, 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 11'h050, 1'b1, 1'b0, 11'h051, '0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 11'h050, 1'b1, 1'b0, 11'h051, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) add(1'b1, 1'b1, 11'h052, 1'b1, 1'b0, 11'h053, '0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 11'h052, 1'b1, 1'b0, 11'h053, '0, 1'b0, 1'b1);
        idle(4);

        for (int i = 0; i < vt.size(); i++) begin
            run_cycle(vt[i].va, vt[i].vr, vt[i].vaddr, vt[i].cr, vt[i].cwe, vt[i].caddr,
                      vt[i].cwd, gvr, gcr);
            chk("tbl_vid_ready", gvr, vt[i].evr);
            chk("tbl_cpu_ready", gcr, vt[i].ecr);
        end

        // Reset pulse one cycle after a video read is accepted
        run_cycle(1'b1, 1'b1, 11'h030, 1'b0, 1'b0, '0, '0, gvr, gcr);
        nreset = 1'b0;
        bus.vid_req = 1'b1;
        bus.cpu_req = 1'b1;
        #1;
        check_all_zero("inreset");
        model_reset();
        @(negedge clock);
        cyc++;
        nreset = 1'b1;
        run_cycle(1'b1, 1'b1, 11'h031, 1'b0, 1'b0, '0, '0, gvr, gcr);
        chk("post_reset_vid_ready", gvr, 1'b1);
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, gvr, gcr);

        // Strict video priority instance
        for (int i = 0; i < 12; i++) begin
            bus0.vid_active = 1'b1;
            bus0.vid_req    = 1'b1;
            bus0.cpu_req    = 1'b1;
            #1;
            chk("strict_cpu_ready", bus0.cpu_ready, 1'b0);
            chk("strict_vid_ready", bus0.vid_ready, 1'b1);
            @(negedge clock);
        end
        bus0.vid_req = 1'b0;
        #1;
        chk("strict_cpu_after_vid", bus0.cpu_ready, 1'b1);
        @(negedge clock);
        bus0.cpu_req = 1'b0;

        // Randomized traffic with hold-until-accepted requesters
        vpend = 1'b0; cpend = 1'b0;
        vr = 1'b0; cr = 1'b0; cwe = 1'b0;
        vaddr = '0; caddr = '0; cwd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!vpend) begin
                vr    = ($urandom_range(0, 2) != 0);
                vaddr = AW'($urandom_range(0, 15));
            end
            if (!cpend) begin
                cr    = ($urandom_range(0, 2) != 0);
                cwe   = $urandom_range(0, 1) != 0;
                caddr = AW'($urandom_range(0, 15));
                cwd   = DW'($urandom);
            end
            va = ($urandom_range(0, 9) < 7);
            run_cycle(va, vr, vaddr, cr, cwe, caddr, cwd, gvr, gcr);
            vpend = vr && !gvr;
            cpend = cr && !gcr;
        end
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, gvr, gcr);
        chk("drained", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares one single-port synchronous video RAM (tile or map BRAM) between two requesters.
- The VGA tile/map fetcher is the video requester, read-only.
- The rj32 data bus is the CPU requester, read/write.
Video has priority during active display, with a starvation guard for the CPU; the CPU has priority during blanking. The block sits between the CPU data port, the VGA front-panel fetch logic and the RAM, and registers all RAM-side signals.

Parameters:
AW, 11, RAM address width
DW, 16, RAM data width
STARVE_MAX, 8, max consecutive cycles CPU may lose a conflict during active display; 0 = strict video priority

Ports:
clock  in  1  single clock for block and RAM
nreset  in  1  asynchronous active-low reset
vid_active  in  1  1 = active display region, video priority; 0 = blanking, CPU priority
vid_req  in  1  video read request
vid_addr  in  AW  video read address
vid_ready  out  1  video request accepted this cycle (combinational)
vid_rvalid  out  1  vid_rdata valid this cycle
vid_rdata  out  DW  video read data
cpu_req  in  1  CPU request
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ready  out  1  CPU request accepted this cycle (combinational)
cpu_rvalid  out  1  cpu_rdata valid this cycle
cpu_rdata  out  DW  CPU read data
mem_en  out  1  RAM enable (registered)
mem_we  out  1  RAM write enable (registered)
mem_addr  out  AW  RAM address (registered)
mem_wdata  out  DW  RAM write data (registered)
mem_rdata  in  DW  RAM read data, valid one cycle after mem_en

Behaviour:
- Handshake: valid/ready. A request is accepted in a cycle where req=1 and ready=1. The requester must hold address/data/we stable until accepted. At most one acceptance per cycle; throughput 1 op/cycle.
- Arbitration (combinational, per cycle):
  - Only one requester asserts: it wins.
  - Both assert, vid_active=0: CPU wins.
  - Both assert, vid_active=1: video wins unless STARVE_MAX!=0 and starve_cnt==STARVE_MAX; then CPU wins.
- starve_cnt: width clog2(STARVE_MAX+1).
  - Increments each cycle with cpu_req=1 and cpu_ready=0, saturating at STARVE_MAX.
  - Clears on CPU acceptance or cpu_req=0.
- RAM stage: an op accepted in cycle t drives mem_en=1, mem_we=cpu_we (0 for video), mem_addr and mem_wdata in cycle t+1 (registered).
  - No acceptance: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last value.
- Read return:
  - mem_rdata valid in t+2.
  - A 2-stage owner tag (none/vid/cpu) travels with the op.
  - At the end of t+2, mem_rdata is captured into the owner's rdata register, and that rvalid is high for exactly cycle t+3.
  - Fixed latency: 3 cycles from acceptance to rvalid.
  - rdata holds its value until the next read for that owner.
  - CPU writes produce no rvalid.
- Ordering: RAM ops issue in acceptance order. A read accepted after a write to the same address returns the new data; a read accepted before it returns the old data. No forwarding is needed.
- vid_active may change any cycle; it affects only same-cycle arbitration. starve_cnt is not cleared by vid_active.
- Reset:
  - While nreset=0: vid_ready=cpu_ready=0, regardless of requests.
  - Async assertion clears mem_en, mem_we, mem_addr, mem_wdata, both tag stages, vid_rvalid, cpu_rvalid, vid_rdata, cpu_rdata and starve_cnt to 0.
  - In-flight ops are discarded; no rvalid is produced for them after reset release.

Test Plan:
- Video only, vid_active=1, vid_req with addr 0x010..0x013 on 4 consecutive cycles, RAM preloaded with data=addr -> vid_ready=1 each cycle; vid_rvalid high 4 cycles starting 3 cycles after first accept; vid_rdata 0x0010..0x0013 in order.
- CPU write 0x0123 to 0x7FF, then CPU read 0x7FF next cycle, no video -> mem_we=1 one cycle then mem_en read; cpu_rvalid 3 cycles after read accept with cpu_rdata=0x0123; no cpu_rvalid for the write.
- Conflict with vid_active=1, STARVE_MAX=8, both requesting continuously -> video wins 8 cycles, CPU accepted on cycle 9, video wins cycles 10-17, CPU wins cycle 18.
- Conflict with vid_active=0 -> CPU accepted first cycle. Repeat with STARVE_MAX=0 and vid_active=1 -> CPU never accepted while vid_req stays 1.
- Same-cycle vid_active 1->0 while CPU already starved 3 cycles -> CPU accepted that cycle; starve_cnt returns to 0.
- nreset pulsed low one cycle after a video read accept -> no vid_rvalid; mem_en=0 and all outputs 0 during reset; normal operation resumes the first cycle after release.
